chan_mux_rr: RTL and testbench
==============================

CHAN_MUX_RR -- requirements
Module: chan_mux_rr

Interface
REQ-001 Parameter WIDTH, default 8, sets the bit width of each data channel; legal values are 1 or greater.
REQ-002 Parameter CHANNELS, default 8, sets the number of input channels; legal values are 2 or greater.
REQ-003 Localparam SELW SHALL equal ceil(log2(CHANNELS)).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous reset, active-low.
REQ-006 in_data  input  CHANNELS*WIDTH  concatenated channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  CHANNELS  per-channel valid.
REQ-008 in_ready  output  CHANNELS  per-channel ready.
REQ-009 mode  input  1  0 means fixed select, 1 means round-robin arbitration.
REQ-010 sel  input  SELW  channel index used in fixed mode.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_chan  output  SELW  index of the channel whose data is in out_data.
REQ-013 out_valid  output  1  output register holds a word.
REQ-014 out_ready  input  1  downstream accepts the word.

Function
REQ-015 The block SHALL contain a single-entry output register with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 load_en SHALL be asserted when the state is EMPTY, or when out_valid=1 and out_ready=1 in the same cycle.
REQ-017 In fixed mode (mode=0), the grant SHALL go to channel sel only when sel<CHANNELS and in_valid[sel]=1; otherwise there is no grant.
REQ-018 In RR mode (mode=1), the grant SHALL go to the first channel with in_valid set, searching circularly from ptr+1 (mod CHANNELS) through ptr.
REQ-019 in_ready[g] SHALL be driven to load_en for the granted channel g, and all other bits of in_ready SHALL be 0; in_ready is combinational and does not depend on in_valid[g] beyond the grant decision.
REQ-020 A transfer SHALL occur when load_en=1 and a grant exists; on the next edge: out_data = channel g data, out_chan = g, out_valid = 1.
REQ-021 When load_en=1 and there is no grant, the next edge SHALL produce out_valid=0, and out_data and out_chan SHALL hold their previous values.
REQ-022 Input-to-output latency SHALL be exactly 1 cycle.
REQ-023 Back-to-back transfers SHALL sustain 1 word per cycle while out_ready=1.
REQ-024 While out_valid=1 and out_ready=0, out_data, out_chan and out_valid SHALL stay stable, and all in_ready bits SHALL be 0.
REQ-025 ptr SHALL update to g only on an RR-mode transfer; it is unchanged by fixed-mode transfers, by idle cycles and by mode changes.
REQ-026 The RR search at ptr=CHANNELS-1 SHALL wrap to channel 0.
REQ-027 A change of mode or sel SHALL affect only the grant computed in that cycle and SHALL never modify a word already held in the output register.
REQ-028 A simultaneous drain and load in the same cycle SHALL replace the output word without any bubble cycle.
REQ-029 When CHANNELS is not a power of two, no index at or above CHANNELS SHALL ever be granted or appear on out_chan.

Reset
REQ-030 Assertion of rst_n=0 SHALL immediately, without waiting for a clock edge, set out_valid=0, out_data=0, out_chan=0 and ptr=CHANNELS-1, so that the first RR search starts at channel 0.
REQ-031 During reset, all in_ready bits SHALL be 0.
REQ-032 Reset asserted in mid-operation SHALL discard the held word with no transfer reported.
REQ-033 After rst_n deasserts, the first transfer SHALL occur no earlier than the first rising edge on which rst_n=1.

Verification
REQ-034 Fixed mode, WIDTH=8, CHANNELS=8: sel=5, in_valid=8'h20, ch5 data=8'hA5, out_ready=1 -> the next cycle gives out_data=A5, out_chan=5, out_valid=1, and in_ready=8'h20 during the accept cycle.
REQ-035 RR mode, in_valid=8'hFF held, out_ready=1 from reset -> out_chan goes 0,1,2,...,7,0 on consecutive cycles, with no gaps.
REQ-036 RR mode, in_valid=8'h81, ptr=7 after a ch7 grant -> next grants alternate 0,7,0,7; with only ch3 valid, ch3 is granted every cycle.
REQ-037 Backpressure: out_valid=1, out_ready=0 for 4 cycles while inputs change -> out_data and out_chan stay constant and in_ready=0; when out_ready rises, the held word drains and the new word loads on the same edge.
REQ-038 Fixed mode with sel=3 and in_valid[3]=0 -> no grant and out_valid drops after the drain; CHANNELS=5 with sel=6 -> never granted.
REQ-039 Assert rst_n low between clock edges while FULL -> out_valid=0, out_data=0 and out_chan=0 immediately; after release in RR mode with all channels valid, the first grant is channel 0.

Source files
------------

// File: rtl/chan_mux_rr.sv
// ============================================================================
// Module      : chan_mux_rr
// Description : N-channel to 1 mux with fixed-select or round-robin grant,
//               feeding a single-entry registered output stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chan_mux_rr #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  localparam int SELW    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam logic [SELW:0]   c_chans = (SELW+1)'(CHANNELS);
  localparam logic [SELW-1:0] c_last  = SELW'(CHANNELS-1);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SELW-1:0]    r_ptr;
  logic [WIDTH-1:0]   r_out_data;
  logic [SELW-1:0]    r_out_chan;
  logic               w_load_en;
  logic               w_gnt_valid;
  logic [SELW-1:0]    w_gnt_idx;
  logic [SELW:0]      w_cand;
  logic [WIDTH-1:0]   w_gnt_data;

  // Reset gates load_en so no channel sees ready while rst_n is low.
  assign w_load_en  = rst_n && ((r_state == EMPTY) || out_ready);
  assign w_gnt_data = in_data[w_gnt_idx*WIDTH +: WIDTH];

  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_idx   = '0;
    w_cand      = '0;
    if (!mode) begin
      if ({1'b0, sel} < c_chans) begin
        if (in_valid[sel]) begin
          w_gnt_valid = 1'b1;
          w_gnt_idx   = sel;
        end
      end
    end else begin
      // Circular search ptr+1 .. ptr; candidate index folded back below CHANNELS.
      for (int i = 1; i <= CHANNELS; i++) begin
        w_cand = {1'b0, r_ptr} + (SELW+1)'(i);
        if (w_cand >= c_chans) begin
          w_cand = w_cand - c_chans;
        end
        if (!w_gnt_valid && in_valid[w_cand[SELW-1:0]]) begin
          w_gnt_valid = 1'b1;
          w_gnt_idx   = w_cand[SELW-1:0];
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (w_load_en && w_gnt_valid) begin
      in_ready[w_gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_load_en) begin
      w_state_nxt = w_gnt_valid ? FULL : EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data <= '0;
      r_out_chan <= '0;
      r_ptr      <= c_last;
    end else if (w_load_en && w_gnt_valid) begin
      r_out_data <= w_gnt_data;
      r_out_chan <= w_gnt_idx;
      if (mode) begin
        r_ptr <= w_gnt_idx;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign out_valid = (r_state == FULL);

endmodule

`default_nettype wire

// File: tb/tb_chan_mux_rr.sv
// ============================================================================
// Module      : tb_chan_mux_rr
// Description : Directed scoreboard bench for chan_mux_rr (8-channel and
//               5-channel instances).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chan_mux_rr;

  logic        clk;
  logic        rst_n;
  logic [63:0] in_data;
  logic [7:0]  in_valid;
  logic [7:0]  in_ready;
  logic        mode;
  logic [2:0]  sel;
  logic [7:0]  out_data;
  logic [2:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  logic [39:0] in_data5;
  logic [4:0]  in_valid5;
  logic [4:0]  in_ready5;
  logic        mode5;
  logic [2:0]  sel5;
  logic [7:0]  out_data5;
  logic [2:0]  out_chan5;
  logic        out_valid5;
  logic        out_ready5;

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] sb[$];

  chan_mux_rr #(.WIDTH(8), .CHANNELS(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
  );

  chan_mux_rr #(.WIDTH(8), .CHANNELS(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data5), .in_valid(in_valid5),
    .in_ready(in_ready5), .mode(mode5), .sel(sel5), .out_data(out_data5),
    .out_chan(out_chan5), .out_valid(out_valid5), .out_ready(out_ready5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] dat(input int i);
    if (i == 5) return 8'hA5;
    return 8'(8'hC0 + i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch);
    sb.push_back({8'(ch), dat(ch)});
  endtask

  // Expect channel ch to be granted this cycle and appear on the output next cycle.
  task automatic rr_expect(input int ch);
    #1;
    chk("in_ready_grant", 32'(in_ready), 32'(8'(1) << ch));
    push(ch);
    step();
    chk("out_chan_seq", 32'(out_chan), 32'(ch));
    chk("out_valid_seq", 32'(out_valid), 32'd1);
  endtask

  // Scoreboard monitor: a word drains on the coming edge when valid && ready.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got chan %0d data %0h expected no word", out_chan, out_data);
        end else begin
          e = sb.pop_front();
          if ({5'd0, out_chan} !== e[15:8] || out_data !== e[7:0]) begin
            n_fail++;
            $display("FAIL sb_word: got chan %0d data %0h expected chan %0d data %0h",
                     out_chan, out_data, e[15:8], e[7:0]);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bp_valid[4];
    int seq4[8];
    bp_valid = '{8'hFF, 8'h0F, 8'hF0, 8'h55};
    seq4 = '{7, 0, 7, 0, 7, 3, 3, 3};

    rst_n = 1'b0; mode = 1'b0; sel = 3'd0; in_valid = 8'hFF; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = dat(i);
    for (int i = 0; i < 5; i++) in_data5[i*8 +: 8] = 8'(8'h50 + i);
    mode5 = 1'b0; sel5 = 3'd0; in_valid5 = 5'h00; out_ready5 = 1'b0;

    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_chan", 32'(out_chan), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    in_valid = 8'h00;
    #9 rst_n = 1'b1;

    // Fixed select of channel 5
    step();
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    sel = 3'd5; in_valid = 8'h20; out_ready = 1'b1;
    #1;
    chk("fix_in_ready", 32'(in_ready), 32'h20);
    push(5);
    step();
    chk("fix_out_valid", 32'(out_valid), 32'd1);
    chk("fix_out_chan", 32'(out_chan), 32'd5);
    in_valid = 8'h00;
    step();
    chk("fix_drain_empty", 32'(out_valid), 32'd0);

    // Fixed select of an invalid channel
    sel = 3'd3; in_valid = 8'hF7;
    #1;
    chk("fix_nogrant_ready", 32'(in_ready), 32'd0);
    step();
    chk("fix_nogrant_valid", 32'(out_valid), 32'd0);

    // Round robin, all valid: ptr still at 7 from reset
    mode = 1'b1; in_valid = 8'hFF;
    for (int k = 0; k < 9; k++) rr_expect(k % 8);

    // Two-channel alternation, then single channel
    in_valid = 8'h81;
    for (int k = 0; k < 5; k++) rr_expect(seq4[k]);
    in_valid = 8'h08;
    for (int k = 5; k < 8; k++) rr_expect(seq4[k]);

    // Backpressure with changing inputs
    in_valid = 8'h10;
    rr_expect(4);
    out_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      in_valid = bp_valid[j]; mode = j[0]; sel = 3'(j);
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      step();
      chk("bp_out_data", 32'(out_data), 32'(dat(4)));
      chk("bp_out_chan", 32'(out_chan), 32'd4);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    mode = 1'b1; in_valid = 8'h04; out_ready = 1'b1;
    rr_expect(2);
    in_valid = 8'h00;
    step();
    chk("bp_after_empty", 32'(out_valid), 32'd0);

    // Fixed-mode transfer leaves ptr alone
    mode = 1'b0; sel = 3'd1; in_valid = 8'h02;
    #1;
    chk("fix2_in_ready", 32'(in_ready), 32'h02);
    push(1);
    step();
    chk("fix2_out_chan", 32'(out_chan), 32'd1);
    mode = 1'b1; in_valid = 8'hFF;
    rr_expect(3);
    in_valid = 8'h00;
    step();

    // Asynchronous reset while FULL
    in_valid = 8'h40; out_ready = 1'b0;
    rr_expect(6);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
    chk("arst_out_chan", 32'(out_chan), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    sb.delete();
    in_valid = 8'hFF; out_ready = 1'b1;
    #1 rst_n = 1'b1;
    rr_expect(0);
    in_valid = 8'h00;
    step();

    // Five-channel instance: out-of-range sel, then RR wrap at 4
    sel5 = 3'd6; in_valid5 = 5'h1F; out_ready5 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("c5_sel6_ready", 32'(in_ready5), 32'd0);
      step();
      chk("c5_sel6_valid", 32'(out_valid5), 32'd0);
    end
    mode5 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("c5_rr_chan", 32'(out_chan5), 32'(k % 5));
      chk("c5_rr_data", 32'(out_data5), 32'(8'h50 + (k % 5)));
    end

    step();
    step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
